// File: rtl/instr_mem_loader.sv
// Unpacks 32-bit instruction words into big-endian byte writes to a 256x8 store, one session per start.
// Latency: word accepted at N, bytes written N+1..N+4; in_ready low while writing (1 word / 5 cycles).
module instr_mem_loader #(
    parameter logic [7:0] BASE_ADDR = 8'h00,
    parameter int         MAX_BYTES = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        in_valid,
    input  logic [31:0] in_word,
    input  logic        in_last,
    output logic        in_ready,
    output logic        mem_we,
    output logic [7:0]  mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        busy,
    output logic        done,
    output logic        overflow,
    output logic [8:0]  byte_count
);

    localparam logic [8:0] LIMIT = 9'(MAX_BYTES - 4);

    typedef enum logic [2:0] {
        IDLE,
        ACCEPT,
        WRITE,
        DONE,
        ERROR
    } state_t;

    state_t      r_state;
    logic [7:0]  r_addr;
    logic [8:0]  r_count;
    logic [31:0] r_word;
    logic        r_last;
    logic [1:0]  r_idx;
    logic        r_rdy;
    logic        r_we;
    logic        r_busy;
    logic        r_done;
    logic        r_ovf;
    logic [8:0]  w_count_nxt;

    assign w_count_nxt = r_count + 9'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_addr  <= BASE_ADDR;
            r_count <= '0;
            r_word  <= '0;
            r_last  <= 1'b0;
            r_idx   <= '0;
            r_rdy   <= 1'b0;
            r_we    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE, ERROR: begin
                    if (start) begin
                        r_state <= ACCEPT;
                        r_addr  <= BASE_ADDR;
                        r_count <= '0;
                        r_done  <= 1'b0;
                        r_ovf   <= 1'b0;
                        r_busy  <= 1'b1;
                        r_rdy   <= 1'b1;
                    end
                end
                ACCEPT: begin
                    // r_rdy already encodes the capacity check; count is frozen here
                    if (in_valid && r_rdy) begin
                        r_word  <= in_word;
                        r_last  <= in_last;
                        r_idx   <= '0;
                        r_state <= WRITE;
                        r_rdy   <= 1'b0;
                        r_we    <= 1'b1;
                    end else if (in_valid) begin
                        r_state <= ERROR;
                        r_ovf   <= 1'b1;
                        r_busy  <= 1'b0;
                        r_rdy   <= 1'b0;
                    end
                end
                WRITE: begin
                    r_addr  <= r_addr + 8'd1;
                    r_count <= w_count_nxt;
                    r_idx   <= r_idx + 2'd1;
                    if (r_idx == 2'd3) begin
                        r_we <= 1'b0;
                        if (r_last) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state <= ACCEPT;
                            r_rdy   <= (w_count_nxt <= LIMIT);
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_we    <= 1'b0;
                    r_rdy   <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        mem_wdata = r_word[31:24];
        case (r_idx)
            2'd1:    mem_wdata = r_word[23:16];
            2'd2:    mem_wdata = r_word[15:8];
            2'd3:    mem_wdata = r_word[7:0];
            default: mem_wdata = r_word[31:24];
        endcase
    end

    assign in_ready   = r_rdy;
    assign mem_we     = r_we;
    assign mem_addr   = r_addr;
    assign busy       = r_busy;
    assign done       = r_done;
    assign overflow   = r_ovf;
    assign byte_count = r_count;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Two loaders (default parameters, and BASE_ADDR=FE / MAX_BYTES=8) share one stimulus stream
// and are each compared every cycle against a session-level model, plus pinned literal checks.
module tb_instr_mem_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic [31:0] in_word = '0;

    logic       rdy[2], we[2], bsy[2], dn[2], ovf[2];
    logic [7:0] addr[2], wd[2];
    logic [8:0] bc[2];

    always #5 clk = ~clk;

    instr_mem_loader dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_word(in_word),
        .in_last(in_last), .in_ready(rdy[0]), .mem_we(we[0]), .mem_addr(addr[0]),
        .mem_wdata(wd[0]), .busy(bsy[0]), .done(dn[0]), .overflow(ovf[0]), .byte_count(bc[0])
    );

    instr_mem_loader #(.BASE_ADDR(8'hFE), .MAX_BYTES(8)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_word(in_word),
        .in_last(in_last), .in_ready(rdy[1]), .mem_we(we[1]), .mem_addr(addr[1]),
        .mem_wdata(wd[1]), .busy(bsy[1]), .done(dn[1]), .overflow(ovf[1]), .byte_count(bc[1])
    );

    int base_p[2] = '{0, 254};
    int max_p[2]  = '{256, 8};

    // Session model: open flag, outcome (0 none, 1 done, 2 overflow), bytes written, bytes pending
    int          m_open[2], m_end[2], m_count[2], m_wr[2];
    logic [31:0] m_word[2];
    logic        m_last[2];

    int          n_vec = 0;
    int          n_bad = 0;
    int          cyc = 0;
    logic        acc0;
    logic [15:0] log0[$];
    logic [15:0] log1[$];
    int          rdy_q[$];

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_open[i] = 0; m_end[i] = 0; m_count[i] = 0; m_wr[i] = 0;
            m_word[i] = '0; m_last[i] = 1'b0;
        end
    endtask

    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            if (m_wr[i] > 0) begin
                m_count[i]++;
                m_wr[i]--;
                if (m_wr[i] == 0 && m_last[i]) begin
                    m_open[i] = 0;
                    m_end[i]  = 1;
                end
            end else if (m_open[i] != 0) begin
                if (in_valid) begin
                    if (m_count[i] <= max_p[i] - 4) begin
                        m_word[i] = in_word;
                        m_last[i] = in_last;
                        m_wr[i]   = 4;
                    end else begin
                        m_open[i] = 0;
                        m_end[i]  = 2;
                    end
                end
            end else if (start) begin
                m_open[i]  = 1;
                m_end[i]   = 0;
                m_count[i] = 0;
            end
        end
    endtask

    task automatic compare();
        int exp_rdy;
        for (int i = 0; i < 2; i++) begin
            exp_rdy = (m_open[i] != 0 && m_wr[i] == 0 && m_count[i] <= max_p[i] - 4) ? 1 : 0;
            chk($sformatf("in_ready[%0d]", i), rdy[i], exp_rdy);
            chk($sformatf("mem_we[%0d]", i), we[i], (m_wr[i] > 0) ? 1 : 0);
            chk($sformatf("busy[%0d]", i), bsy[i], m_open[i]);
            chk($sformatf("done[%0d]", i), dn[i], (m_end[i] == 1) ? 1 : 0);
            chk($sformatf("overflow[%0d]", i), ovf[i], (m_end[i] == 2) ? 1 : 0);
            chk($sformatf("byte_count[%0d]", i), bc[i], m_count[i]);
            if (m_wr[i] > 0) begin
                chk($sformatf("mem_addr[%0d]", i), addr[i], (base_p[i] + m_count[i]) % 256);
                chk($sformatf("mem_wdata[%0d]", i), wd[i],
                    int'((m_word[i] >> (8 * (m_wr[i] - 1))) & 32'hFF));
            end
        end
        if (we[0]) log0.push_back({addr[0], wd[0]});
        if (we[1]) log1.push_back({addr[1], wd[1]});
        if (rdy[0]) rdy_q.push_back(cyc);
        acc0 = rdy[0] && in_valid;
    endtask

    task automatic cycle();
        @(negedge clk);
        if (!rst_n) model_reset();
        compare();
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_step();
        cyc++;
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cycle();
        start = 1'b0;
    endtask

    // Offers n words (last flag on the final one), holding in_valid until dut0 takes each
    task automatic feed(input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2,
                        input int n);
        logic [31:0] wv[3];
        int k;
        wv[0] = w0; wv[1] = w1; wv[2] = w2;
        k = 0;
        in_valid = 1'b1;
        for (int t = 0; t < 200 && k < n; t++) begin
            in_word = wv[k];
            in_last = (k == n - 1);
            cycle();
            if (acc0) k++;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_word  = $urandom;
        if (k < n) chk("feed_timeout", k, n);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((m_open[0] != 0 || m_open[1] != 0) && t < 200) begin
            cycle();
            t++;
        end
        if (t >= 200) chk("drain_timeout", t, 0);
    endtask

    task automatic reset_literals(input string tag);
        chk({tag, "_we0"}, we[0], 0);      chk({tag, "_we1"}, we[1], 0);
        chk({tag, "_rdy0"}, rdy[0], 0);    chk({tag, "_busy0"}, bsy[0], 0);
        chk({tag, "_done0"}, dn[0], 0);    chk({tag, "_ovf1"}, ovf[1], 0);
        chk({tag, "_bc0"}, bc[0], 0);      chk({tag, "_bc1"}, bc[1], 0);
        chk({tag, "_addr0"}, addr[0], 8'h00);
        chk({tag, "_addr1"}, addr[1], 8'hFE);
        chk({tag, "_wdata0"}, wd[0], 0);
    endtask

    initial begin
        model_reset();
        cycle();
        reset_literals("reset");
        rst_n = 1'b1;
        cycle();

        // Single word, then a restart into a wrapping single word
        log0.delete(); log1.delete();
        pulse_start();
        feed(32'hE3A01005, 32'h0, 32'h0, 1);
        drain();
        chk("single_len", log0.size(), 4);
        if (log0.size() == 4) begin
            chk("single_b0", log0[0], 16'h00E3); chk("single_b1", log0[1], 16'h01A0);
            chk("single_b2", log0[2], 16'h0210); chk("single_b3", log0[3], 16'h0305);
        end
        chk("single_done", dn[0], 1);
        chk("single_bc", bc[0], 4);

        log0.delete(); log1.delete();
        pulse_start();
        chk("restart_done", dn[0], 0);
        chk("restart_bc", bc[0], 0);
        chk("restart_busy", bsy[0], 1);
        feed(32'h11223344, 32'h0, 32'h0, 1);
        drain();
        chk("wrap_len", log1.size(), 4);
        if (log1.size() == 4) begin
            chk("wrap_b0", log1[0], 16'hFE11); chk("wrap_b1", log1[1], 16'hFF22);
            chk("wrap_b2", log1[2], 16'h0033); chk("wrap_b3", log1[3], 16'h0144);
        end
        chk("wrap_done", dn[1], 1);

        // Three words back-to-back: full run on dut0, capacity abort on dut1
        log0.delete(); log1.delete(); rdy_q.delete();
        pulse_start();
        feed(32'hA0A1A2A3, 32'hB0B1B2B3, 32'hC0C1C2C3, 3);
        drain();
        chk("bp_len", log0.size(), 12);
        for (int i = 0; i < 12; i++)
            chk($sformatf("bp_addr%0d", i), (i < log0.size()) ? int'(log0[i][15:8]) : -1, i);
        chk("bp_pulses", rdy_q.size(), 3);
        if (rdy_q.size() == 3) begin
            chk("bp_gap1", rdy_q[1] - rdy_q[0], 5);
            chk("bp_gap2", rdy_q[2] - rdy_q[1], 5);
        end
        chk("bp_bc", bc[0], 12);
        chk("ovf_flag", ovf[1], 1);
        chk("ovf_bc", bc[1], 8);
        chk("ovf_len", log1.size(), 8);
        cycle();
        chk("ovf_we", we[1], 0);

        // Reset during the third byte strobe
        pulse_start();
        feed(32'hA55A3CC3, 32'h0, 32'h0, 2);
        for (int t = 0; t < 10 && m_wr[0] != 2; t++) cycle();
        chk("midrst_reach", m_wr[0], 2);
        rst_n = 1'b0;
        #1;
        reset_literals("midrst");
        model_reset();
        cycle();
        rst_n = 1'b1;
        log0.delete(); log1.delete();
        pulse_start();
        feed(32'h01020304, 32'h0, 32'h0, 1);
        drain();
        chk("post_rst_addr0", (log0.size() > 0) ? int'(log0[0]) : -1, 16'h0001);
        chk("post_rst_addr1", (log1.size() > 0) ? int'(log1[0]) : -1, 16'hFE01);

        // Randomized traffic, including occasional asynchronous resets
        for (int t = 0; t < 5000; t++) begin
            rst_n    = ($urandom_range(0, 299) != 0);
            start    = ($urandom_range(0, 9) == 0);
            in_valid = $urandom_range(0, 1);
            in_word  = $urandom;
            in_last  = (t < 2500) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 149) == 0);
            cycle();
        end
        rst_n = 1'b1; start = 1'b0; in_valid = 1'b0;
        cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
